gpio_in: RTL and testbench
==========================

Name: gpio_in

Overview:
Memory-mapped GPIO input port, the input-direction counterpart of the GPIO output peripheral on the same byte-addressed bus (addr/be/wdata/we, read data on q). It synchronizes external input pins, optionally debounces them, detects enabled rising/falling edges into write-1-to-clear pending bits, and raises a level interrupt to the core.

Parameters:
WIDTH, 4, number of input pins (1..8)
DB_W, 8, width of debounce threshold register and per-pin counters
DB_RESET, 0, reset value of the debounce threshold register

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
addr  input  8  byte address of register access
be  input  4  byte enables for writes; only be[0] used
wdata  input  32  write data
we  input  1  write strobe, one write per cycle while high
pins  input  WIDTH  asynchronous external input pins
q  output  32  registered read data for addr of previous cycle
irq  output  1  interrupt, high while any pending bit set

Behaviour:
- Register map, byte offsets, unmapped addresses read 0 and ignore writes:
  0x00 DATA (RO) = debounced pin state, zero-extended. 0x04 RISE_EN (RW, WIDTH bits). 0x08 FALL_EN (RW, WIDTH bits). 0x0C PENDING (R/W1C). 0x10 DB (RW, DB_W bits), debounce threshold.
- Write occurs on a clock edge when we=1 and be[0]=1; bits above a register's width are ignored; we=1 with be[0]=0 has no effect. Writes to DATA are ignored.
- Read: q <= value of register at addr, updated every cycle regardless of we. Latency 1 cycle. A read and a write to the same register in one cycle return the pre-write value.
- Reset (rst=0, asynchronous): sync stages, stable state, RISE_EN, FALL_EN, PENDING, debounce counters = 0; DB = DB_RESET; q = 0; irq = 0. Reset mid-debounce discards the count.
- Synchronizer: two flops per pin (s0 <= pins, s1 <= s0). No logic on s0.
- Debounce per pin i: cnt[i] increments while s1[i] != stable[i], cleared to 0 when equal. stable[i] <= s1[i] on the edge where the mismatch has been present for max(DB,1) consecutive cycles including the current one; cnt[i] clears on that edge. DB=0 and DB=1 both mean no filtering. The counter never wraps (it saturates at DB-1 before the update). Writing DB mid-count applies from the next cycle with the existing count.
- Edge detect: on the edge where stable[i] goes 0->1, PENDING[i] <= 1 if RISE_EN[i]. On 1->0, PENDING[i] <= 1 if FALL_EN[i]. Enables are sampled in that same cycle.
- W1C: a write to 0x0C clears PENDING bits where wdata bit = 1. A set event and a clear on the same bit in the same cycle: set wins.
- Clearing an enable does not clear existing pending bits.
- irq = OR of PENDING (combinational from the register, glitch-free). irq goes high the cycle after the stable-state update.
- Latency with DB<=1: pin change before edge 1 -> s0 at edge 1, s1 at edge 2, stable/PENDING at edge 3, irq high after edge 3. A DATA read issued at edge 3 shows the value on q after edge 4.
- A pin pulse shorter than DB cycles (after sync) never changes stable and never sets pending.
- Pins high when reset deasserts cause stable to rise 3 cycles later. No pending is set, because the enables are 0.

Test Plan:
- Reset then pins=4'b1010, DB=0, read 0x00 -> q=0x0000000A no later than 5 cycles after the pin change; irq stays 0 (enables 0).
- RISE_EN=4'b0001, pin0 0->1 -> PENDING=0x1 and irq=1 three edges after the change; write 0x0C wdata=0x1 -> PENDING=0 and irq=0 the next cycle.
- FALL_EN=4'b1000, pin3 1->0 in the same cycle as W1C of bit3 is issued -> PENDING[3] remains 1 (set wins).
- DB=5, pin1 pulse high for 4 cycles -> DATA[1] stays 0, no pending. Pin1 held high 5 cycles -> DATA[1]=1 exactly 5 edges after s1 rises.
- Write with be=4'b0000 to RISE_EN (wdata=0xF) -> RISE_EN unchanged. Write to 0x00 and to 0x20 -> no effect, reads return DATA and 0 respectively.
- Assert rst=0 mid-debounce with PENDING=0xF -> q, irq, PENDING drop to 0 immediately (asynchronous). DB reads DB_RESET after release.

Source files
------------

// File: rtl/gpio_in_if.sv
// Register bus for the GPIO input port: byte address, byte enables, write data
// and strobe toward the peripheral, registered read data back.
interface gpio_in_if;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] q;

    modport master (output addr, be, wdata, we, input q);
    modport slave  (input addr, be, wdata, we, output q);
endinterface

// File: rtl/gpio_in.sv
// GPIO input port: per-pin two-flop sync plus debounce, enabled edge capture
// into write-1-to-clear pending bits, and a level interrupt.
module gpio_in_pin #(
    parameter int unsigned DB_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pin,
    input  logic [DB_W-1:0] thr,
    output logic            stable,
    output logic            rise,
    output logic            fall
);
    localparam logic [DB_W-1:0] ONE = DB_W'(1);

    logic            s0, s1;
    logic [DB_W-1:0] cnt;
    logic            hit;

    // Fires on the edge completing thr consecutive mismatched cycles; the >=
    // also covers a threshold lowered below the running count.
    assign hit  = (s1 != stable) && (cnt >= thr - ONE);
    assign rise = hit & s1;
    assign fall = hit & ~s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0     <= 1'b0;
            s1     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s0 <= pin;
            s1 <= s0;
            if (s1 == stable) begin
                cnt <= '0;
            end else if (hit) begin
                stable <= s1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end
endmodule

module gpio_in #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DB_W     = 8,
    parameter int unsigned DB_RESET = 0
) (
    input  logic             clk,
    input  logic             rst,
    gpio_in_if.slave         bus,
    input  logic [WIDTH-1:0] pins,
    output logic             irq
);
    localparam logic [7:0] A_DATA = 8'h00;
    localparam logic [7:0] A_RISE = 8'h04;
    localparam logic [7:0] A_FALL = 8'h08;
    localparam logic [7:0] A_PEND = 8'h0C;
    localparam logic [7:0] A_DB   = 8'h10;

    logic [WIDTH-1:0] stable, rise, fall;
    logic [WIDTH-1:0] rise_en, fall_en, pend, clr, set;
    logic [DB_W-1:0]  db, thr;
    logic [31:0]      rdata;
    logic             wr;
    logic             unused_bits;

    assign wr          = bus.we & bus.be[0];
    assign thr         = (db == '0) ? DB_W'(1) : db;
    assign unused_bits = ^{bus.be[3:1], bus.wdata};

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
        gpio_in_pin #(.DB_W(DB_W)) u_pin (
            .clk    (clk),
            .rst    (rst),
            .pin    (pins[gi]),
            .thr    (thr),
            .stable (stable[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi])
        );
    end

    assign set = (rise & rise_en) | (fall & fall_en);
    assign clr = (wr && bus.addr == A_PEND) ? bus.wdata[WIDTH-1:0] : '0;
    assign irq = |pend;

    always_comb begin
        rdata = '0;
        case (bus.addr)
            A_DATA:  rdata[WIDTH-1:0] = stable;
            A_RISE:  rdata[WIDTH-1:0] = rise_en;
            A_FALL:  rdata[WIDTH-1:0] = fall_en;
            A_PEND:  rdata[WIDTH-1:0] = pend;
            A_DB:    rdata[DB_W-1:0]  = db;
            default: rdata = '0;
        endcase
    end

    // New events take priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_en <= '0;
            fall_en <= '0;
            pend    <= '0;
            db      <= DB_W'(DB_RESET);
            bus.q   <= '0;
        end else begin
            bus.q <= rdata;
            pend  <= (pend & ~clr) | set;
            if (wr && bus.addr == A_RISE) rise_en <= bus.wdata[WIDTH-1:0];
            if (wr && bus.addr == A_FALL) fall_en <= bus.wdata[WIDTH-1:0];
            if (wr && bus.addr == A_DB)   db      <= bus.wdata[DB_W-1:0];
        end
    end
endmodule

// File: tb/tb_gpio_in.sv
// Bench for gpio_in: register table plus hand sequences for sync latency,
// edge capture, W1C priority, debounce filtering and async reset.
module tb_gpio_in;
    localparam int unsigned DB_RESET = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pins = '0;
    logic       irq;

    gpio_in_if bus ();

    gpio_in #(.WIDTH(4), .DB_W(8), .DB_RESET(DB_RESET)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .pins (pins),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[13];
    int   total = 0;
    int   bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        bus.we    = 1'b1;
        step();
        bus.we    = 1'b0;
    endtask

    // Expected value queued when the address is driven, checked once q lands.
    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
        sb_t e;
        bus.addr = a;
        bus.we   = 1'b0;
        e.nm  = nm;
        e.exp = exp;
        sb.push_back(e);
        step();
        e = sb.pop_front();
        chk(e.nm, bus.q, e.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'h04, 32'h0000000F, 4'h1, 32'hF};
        tbl[1]  = '{8'h04, 32'hFFFFFFF5, 4'h1, 32'h5};
        tbl[2]  = '{8'h04, 32'h0000000F, 4'h0, 32'h5};
        tbl[3]  = '{8'h08, 32'h00000003, 4'hF, 32'h3};
        tbl[4]  = '{8'h08, 32'h0000000C, 4'hE, 32'h3};
        tbl[5]  = '{8'h10, 32'h000001AB, 4'h1, 32'hAB};
        tbl[6]  = '{8'h10, 32'h00000000, 4'h1, 32'h0};
        tbl[7]  = '{8'h00, 32'h0000000F, 4'h1, 32'hA};
        tbl[8]  = '{8'h20, 32'h0000000F, 4'h1, 32'h0};
        tbl[9]  = '{8'h0C, 32'h0000000F, 4'h1, 32'h0};
        tbl[10] = '{8'h05, 32'h0000000F, 4'h1, 32'h0};
        tbl[11] = '{8'h04, 32'h00000000, 4'h1, 32'h0};
        tbl[12] = '{8'h08, 32'h00000000, 4'h1, 32'h0};

        bus.addr = '0; bus.be = '0; bus.wdata = '0; bus.we = 1'b0;
        step();
        step();
        chk("rst_q", bus.q, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b1;

        rd(8'h10, DB_RESET, "db_after_rst");
        rd(8'h0C, 32'h0, "pend_after_rst");

        // sync latency: stable at edge 3, visible on q after edge 4
        pins = 4'b1010;
        rd(8'h00, 32'h0, "data_e1");
        rd(8'h00, 32'h0, "data_e2");
        rd(8'h00, 32'h0, "data_e3");
        rd(8'h00, 32'hA, "data_e4");
        chk("irq_no_en", {31'b0, irq}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            wr(tbl[i].a, tbl[i].d, tbl[i].b);
            rd(tbl[i].a, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // same-cycle read and write returns the old value
        wr(8'h04, 32'h1, 4'h1);
        chk("rd_wr_same", bus.q, 32'h0);
        rd(8'h04, 32'h1, "rise_en_rb");

        pins = 4'b1011;
        step();
        chk("rise_irq_e1", {31'b0, irq}, 32'h0);
        step();
        chk("rise_irq_e2", {31'b0, irq}, 32'h0);
        step();
        chk("rise_irq_e3", {31'b0, irq}, 32'h1);
        rd(8'h0C, 32'h1, "rise_pend");
        wr(8'h0C, 32'h1, 4'h1);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        rd(8'h0C, 32'h0, "w1c_pend");

        // fall event and its clear land on the same edge
        wr(8'h08, 32'h8, 4'h1);
        pins = 4'b0011;
        step();
        step();
        wr(8'h0C, 32'h8, 4'h1);
        chk("set_wins_irq", {31'b0, irq}, 32'h1);
        rd(8'h0C, 32'h8, "set_wins_pend");
        wr(8'h08, 32'h0, 4'h1);
        rd(8'h0C, 32'h8, "en_clear_keeps");
        wr(8'h0C, 32'h8, 4'h1);
        rd(8'h0C, 32'h0, "pend_cleared");

        pins = 4'b0001;
        repeat (4) step();
        wr(8'h04, 32'h2, 4'h1);
        wr(8'h10, 32'h5, 4'h1);
        rd(8'h00, 32'h1, "data_pre_db");

        pins[1] = 1'b1;
        repeat (4) step();
        pins[1] = 1'b0;
        repeat (8) step();
        rd(8'h00, 32'h1, "short_pulse_data");
        chk("short_pulse_irq", {31'b0, irq}, 32'h0);
        rd(8'h0C, 32'h0, "short_pulse_pend");

        pins = 4'b0011;
        repeat (5) step();
        rd(8'h00, 32'h1, "db_e6");
        chk("db_irq_e6", {31'b0, irq}, 32'h0);
        rd(8'h00, 32'h1, "db_e7");
        chk("db_irq_e7", {31'b0, irq}, 32'h1);
        rd(8'h00, 32'h3, "db_e8");
        rd(8'h0C, 32'h2, "db_pend");

        wr(8'h10, 32'h0, 4'h1);
        wr(8'h04, 32'hF, 4'h1);
        wr(8'h08, 32'hF, 4'h1);
        wr(8'h0C, 32'hF, 4'h1);
        pins = 4'b1100;
        repeat (4) step();
        rd(8'h0C, 32'hF, "pend_all");
        wr(8'h10, 32'h5, 4'h1);
        pins = 4'b0000;
        repeat (4) step();
        bus.addr = 8'h0C;
        step();
        chk("pre_rst_q", bus.q, 32'hF);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_q", bus.q, 32'h0);
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        pins = 4'b1111;
        step();
        step();
        bus.addr = 8'h00;
        rst = 1'b1;
        rd(8'h00, 32'h0, "rel_e1");
        rd(8'h00, 32'h0, "rel_e2");
        rd(8'h00, 32'h0, "rel_e3");
        rd(8'h00, 32'hF, "rel_e4");
        chk("rel_irq", {31'b0, irq}, 32'h0);
        rd(8'h10, DB_RESET, "rel_db");
        rd(8'h0C, 32'h0, "rel_pend");
        rd(8'h04, 32'h0, "rel_rise_en");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
